// File: rtl/updown_counter_p.sv
// Purpose : parametrised up/down counter with programmable terminal value,
//           parallel load, count enable and wrap/saturate end behaviour.
// Latency : one clock for count/load/clear; o_tc is combinational; o_evt is
//           a registered pulse one cycle after a boundary step.
// Backpressure: none; i_en gates stepping, i_load overrides i_en, i_clr overrides all.
//
// Ports:
//   i_clk    clock, all state changes on the rising edge
//   i_clr    synchronous active-high clear (highest priority)
//   i_en     count enable
//   i_up     direction, 1 = increment, 0 = decrement (only with i_en)
//   i_load   parallel load strobe (priority over i_en)
//   i_d      parallel load value, clamped to i_limit
//   i_limit  terminal count, range is 0..i_limit inclusive
//   o_q      registered count
//   o_tc     terminal count flag for cascading into the next stage's i_en
//   o_evt    one-cycle pulse: previous step wrapped or was clamped at an end
module updown_counter_p #(
  parameter int unsigned WIDTH    = 4,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_up,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_d,
  input  logic [WIDTH-1:0] i_limit,
  output logic [WIDTH-1:0] o_q,
  output logic             o_tc,
  output logic             o_evt
);

  logic [WIDTH-1:0] r_q;
  logic             r_evt;

  logic [WIDTH-1:0] w_q_nxt;
  logic             w_evt_nxt;
  logic             w_at_top;
  logic             w_at_bot;
  logic             w_above;

  // q can sit above i_limit when the limit is lowered at run time; counting
  // up from there is treated as reaching the top end.
  assign w_at_top = (r_q >= i_limit);
  assign w_at_bot = (r_q == '0);
  assign w_above  = (r_q >  i_limit);

  always_comb begin
    w_q_nxt   = r_q;
    w_evt_nxt = 1'b0;
    if (i_load) begin
      w_q_nxt = (i_d > i_limit) ? i_limit : i_d;
    end else if (i_en) begin
      if (i_up) begin
        if (w_at_top) begin
          w_q_nxt   = SATURATE ? i_limit : '0;
          w_evt_nxt = 1'b1;
        end else begin
          w_q_nxt = r_q + 1'b1;
        end
      end else begin
        // Out-of-range value is pulled back to the limit first so a
        // decrement never walks down from above the range.
        if (w_above) begin
          w_q_nxt   = i_limit;
          w_evt_nxt = 1'b1;
        end else if (w_at_bot) begin
          w_q_nxt   = SATURATE ? '0 : i_limit;
          w_evt_nxt = 1'b1;
        end else begin
          w_q_nxt = r_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_q   <= '0;
      r_evt <= 1'b0;
    end else begin
      r_q   <= w_q_nxt;
      r_evt <= w_evt_nxt;
    end
  end

  assign o_q   = r_q;
  assign o_evt = r_evt;
  // Same condition that will produce o_evt on the next edge for in-range q.
  assign o_tc  = i_en & ((i_up & w_at_top) | (~i_up & w_at_bot));

endmodule

// File: tb/tb_updown_counter_p.sv
// Bench for updown_counter_p: drives a wrap and a saturate instance with the
// same stimulus, queues expected results from a behavioural model, and a
// separate monitor compares DUT outputs against the queue.
module tb_updown_counter_p;

  localparam int W = 4;

  logic         clk;
  logic         clr, en, up, load;
  logic [W-1:0] d, limit;
  logic [W-1:0] q_w, q_s;
  logic         tc_w, tc_s, evt_w, evt_s;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int qw; int qs;
    bit ew; bit es;
    bit tw; bit ts;
  } rec_t;

  rec_t sb[$];

  // behavioural model state
  int mq_w = 0;
  int mq_s = 0;

  updown_counter_p #(.WIDTH(W), .SATURATE(1'b0)) u_wrap (
    .i_clk(clk), .i_clr(clr), .i_en(en), .i_up(up), .i_load(load),
    .i_d(d), .i_limit(limit), .o_q(q_w), .o_tc(tc_w), .o_evt(evt_w)
  );

  updown_counter_p #(.WIDTH(W), .SATURATE(1'b1)) u_sat (
    .i_clk(clk), .i_clr(clr), .i_en(en), .i_up(up), .i_load(load),
    .i_d(d), .i_limit(limit), .o_q(q_s), .o_tc(tc_s), .o_evt(evt_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Next value straight from the operation rules.
  function automatic void model(input int q, input int lim, input bit sat,
                                input bit c, input bit l, input bit e,
                                input bit u, input int dv,
                                output int nq, output bit ev);
    nq = q;
    ev = 1'b0;
    if (c) nq = 0;
    else if (l) nq = (dv > lim) ? lim : dv;
    else if (e) begin
      if (u) begin
        if (q + 1 > lim) begin ev = 1'b1; nq = sat ? lim : 0; end
        else nq = q + 1;
      end else begin
        if (q > lim)       begin ev = 1'b1; nq = lim; end
        else if (q == 0)   begin ev = 1'b1; nq = sat ? 0 : lim; end
        else nq = q - 1;
      end
    end
  endfunction

  function automatic bit tc_model(input int q, input int lim, input bit e, input bit u);
    return e && ((u && q >= lim) || (!u && q == 0));
  endfunction

  task automatic step(input bit c, input bit l, input bit e, input bit u,
                      input int dv, input int lim);
    rec_t r;
    int nq;
    bit ev;
    @(negedge clk);
    clr = c; load = l; en = e; up = u;
    d = dv[W-1:0]; limit = lim[W-1:0];
    r.tw = tc_model(mq_w, lim, e, u);
    r.ts = tc_model(mq_s, lim, e, u);
    model(mq_w, lim, 1'b0, c, l, e, u, dv, nq, ev);
    mq_w = nq; r.qw = nq; r.ew = ev;
    model(mq_s, lim, 1'b1, c, l, e, u, dv, nq, ev);
    mq_s = nq; r.qs = nq; r.es = ev;
    #1 sb.push_back(r);
  endtask

  // Monitor: tc is checked mid-cycle with the inputs applied, q/evt after the edge.
  initial begin
    rec_t r;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        chk("tc_wrap", int'(tc_w), int'(sb[0].tw));
        chk("tc_sat",  int'(tc_s), int'(sb[0].ts));
      end
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        r = sb.pop_front();
        chk("q_wrap",   int'(q_w),   r.qw);
        chk("evt_wrap", int'(evt_w), int'(r.ew));
        chk("q_sat",    int'(q_s),   r.qs);
        chk("evt_sat",  int'(evt_s), int'(r.es));
      end
    end
  end

  initial begin
    int waited;
    clr = 1'b1; en = 1'b0; up = 1'b0; load = 1'b0; d = '0; limit = '0;

    // reset, then wrap up over limit 9
    step(1, 0, 0, 0, 0, 9);
    for (int i = 0; i < 12; i++) step(0, 0, 1, 1, 0, 9);
    // wrap down from 2
    step(0, 1, 0, 0, 2, 9);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, 9);
    // saturate at the top, then step down
    step(0, 1, 0, 0, 14, 15);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 0, 15);
    step(0, 0, 1, 0, 0, 15);
    // load clamp with en, then clr beats load
    step(0, 1, 1, 1, 12, 5);
    step(1, 1, 0, 0, 3, 5);
    // runtime limit reduction while counting down
    step(0, 1, 0, 0, 12, 15);
    step(0, 0, 1, 0, 0, 7);
    step(0, 0, 1, 0, 0, 7);
    // limit 0 keeps evt high
    for (int i = 0; i < 3; i++) step(0, 0, 1, i[0], 0, 0);
    // count to 6, hold, clear with en
    step(1, 0, 0, 0, 0, 15);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 1, 0, 15);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 15);
    step(1, 0, 1, 1, 0, 15);
    // full natural range wrap both ways
    step(0, 1, 0, 0, 15, 15);
    step(0, 0, 1, 1, 0, 15);
    step(0, 0, 1, 0, 0, 15);

    // randomized traffic, limit changing at run time
    for (int i = 0; i < 400; i++) begin
      int lim;
      lim = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : int'(limit);
      step($urandom_range(0, 39) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 15), lim);
    end

    @(negedge clk);
    en = 1'b0; load = 1'b0; clr = 1'b0;
    waited = 0;
    while (sb.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    #3;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d entries left expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/updown_counter_p.md
# updown_counter_p

Parametrised synchronous up/down counter with programmable terminal value, parallel load, count enable and selectable wrap/saturate behaviour. It is the general-purpose counter for the counters library, replacing fixed 4-bit up/down counters in timers, address generators and event tallies. It provides a registered overflow/underflow event pulse and a combinational terminal-count flag for cascading.

## Interface
- WIDTH, 4: counter width in bits; legal range 2..32.
- SATURATE, 0: 0 = wrap at the ends of the range, 1 = hold at the ends of the range.
- clk  input  1  clock; all state updates on the rising edge.
- clr  input  1  reset, synchronous, active-high; wins over every other input.
- en  input  1  count enable; no count step when low.
- up  input  1  direction; 1 = increment, 0 = decrement. Sampled only with en.
- load  input  1  parallel load strobe; takes priority over en.
- d  input  WIDTH  parallel load value.
- limit  input  WIDTH  terminal (maximum) count; counting range is 0..limit inclusive.
- q  output  WIDTH  registered count value.
- tc  output  1  combinational terminal count: en & ((up & q>=limit) | (~up & q==0)).
- evt  output  1  registered one-cycle pulse: the previous cycle's step hit an end of the range (wrapped or was clamped).

## Operation
- Priority per rising edge: clr > load > en > hold.
- clr: q <= 0, evt <= 0.
- load: q <= (d > limit) ? limit : d. evt <= 0. en and up are ignored in this cycle.
- en & up, q < limit: q <= q + 1, evt <= 0.
- en & up, q >= limit: wrap mode q <= 0; saturate mode q <= limit. evt <= 1 in both modes.
- en & ~up, q == 0: wrap mode q <= limit; saturate mode q <= 0. evt <= 1.
- en & ~up, 0 < q <= limit: q <= q - 1, evt <= 0.
- en & ~up, q > limit (limit lowered at run time): q <= limit, evt <= 1.
- ~en, no load, no clr: q holds, evt <= 0.
- Arithmetic is WIDTH bits, unsigned. There is no intermediate carry out of bit WIDTH-1. limit = 2^WIDTH-1 gives the full natural range.
- limit == 0: every enabled step produces q = 0 and evt = 1.
- limit is sampled combinationally each cycle. It needs no synchronisation and may change at any time.
- tc is a pure function of current en, up, q and limit. It asserts in the same cycle as the step that will produce evt on the next edge. Chaining: the tc of a low stage drives the en of the next stage.

## Timing
- Reset values: q = 0, evt = 0. tc = 0 whenever en = 0.
- Count latency: one clock; q updates on the edge where en is sampled high.
- Load latency: one clock. The loaded value is visible on q after the edge.
- evt is high for exactly one cycle, in the cycle after the boundary step. Consecutive boundary steps (saturate mode held at the end, or limit = 0) keep evt high continuously.
- clr asserted mid-count: q = 0 on the next edge regardless of load or en. evt is cleared on the same edge.
- Simultaneous load and en: the load wins, and no step or evt occurs.
- Direction change: a change in up takes effect on the next enabled edge, with no dead cycle.

## Test plan
- Reset and wrap up: WIDTH=4, SATURATE=0, limit=9. Apply clr for 1 cycle, then en=1, up=1 for 12 cycles. Required: q = 1..9, 0, 1, 2. tc high while q = 9. evt high for exactly the one cycle in which q = 0.
- Wrap down: limit=9, load d=2, then en=1, up=0 for 4 cycles. Required: q = 2, 1, 0, 9, 8. tc high while q = 0. evt high in the cycle q = 9.
- Saturate: SATURATE=1, limit=15, load d=14, en=1, up=1 for 3 cycles. Required: q = 15, 15, 15. evt high for 2 consecutive cycles. Then up=0 for 1 cycle: q = 14 and evt goes low.
- Load clamp and priority: limit=5. Assert load with d=12 together with en=1, up=1. Required: q = 5, evt = 0. Then load d=3 with clr=1: q = 0.
- Runtime limit reduction: limit=15, q=12. Change limit to 7 with en=1, up=0. Required: q = 7 and evt = 1. Next cycle q = 6 and evt = 0.
- Mid-operation reset and hold: count to q=6, then drop en for 3 cycles. Required: q holds 6, tc = 0, evt = 0. Assert clr together with en=1: q = 0 on that edge.
